// File: rtl/raster_pkg.sv
// Shared rasterizer definitions: default screen geometry,
// pixel type and signed min/max helpers.
package raster_pkg;

  localparam int FRAC_W_DEF   = 4;
  localparam int PIX_W_DEF    = 10;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  function automatic logic signed [31:0] smin(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [31:0] smax(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bbox_axis.sv
// One axis of the bounding-box pipeline: min/max over three
// vertices, floor to pixels, clip to [0, LIMIT], off-screen flag.
module bbox_axis
  import raster_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int LIMIT   = SCREEN_W_DEF - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic signed [COORD_W-1:0] a,
  input  logic signed [COORD_W-1:0] b,
  input  logic signed [COORD_W-1:0] c,
  output logic        [PIX_W-1:0]   pmin,
  output logic        [PIX_W-1:0]   pmax,
  output logic                      off
);

  localparam int PW = COORD_W - FRAC_W + 1;
  localparam logic signed [PW-1:0] LIM = PW'(LIMIT);

  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [PW-1:0]      pxs_t;

  crd_t s1_min_q, s1_min_d;
  crd_t s1_max_q, s1_max_d;
  crd_t s1_c_q,   s1_c_d;
  crd_t s2_min_q, s2_min_d;
  crd_t s2_max_q, s2_max_d;
  logic [PIX_W-1:0] s3_min_q, s3_min_d;
  logic [PIX_W-1:0] s3_max_q, s3_max_d;
  logic             s3_off_q, s3_off_d;

  pxs_t lo;
  pxs_t hi;

  function automatic logic [PIX_W-1:0] clip(input pxs_t p);
    if (p < 0)        return '0;
    else if (p > LIM) return PIX_W'(LIM);
    else              return PIX_W'(p);
  endfunction

  always_comb begin
    s1_min_d = s1_min_q;
    s1_max_d = s1_max_q;
    s1_c_d   = s1_c_q;
    s2_min_d = s2_min_q;
    s2_max_d = s2_max_q;
    s3_min_d = s3_min_q;
    s3_max_d = s3_max_q;
    s3_off_d = s3_off_q;
    // floor(x / 2^FRAC_W) is just the sign-extended integer part
    lo = {s2_min_q[COORD_W-1], s2_min_q[COORD_W-1:FRAC_W]};
    hi = {s2_max_q[COORD_W-1], s2_max_q[COORD_W-1:FRAC_W]};
    if (adv) begin
      s1_min_d = crd_t'(smin(32'(a), 32'(b)));
      s1_max_d = crd_t'(smax(32'(a), 32'(b)));
      s1_c_d   = c;
      s2_min_d = crd_t'(smin(32'(s1_min_q), 32'(s1_c_q)));
      s2_max_d = crd_t'(smax(32'(s1_max_q), 32'(s1_c_q)));
      s3_min_d = clip(lo);
      s3_max_d = clip(hi);
      s3_off_d = (hi < 0) || (lo > LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_min_q <= '0;
      s1_max_q <= '0;
      s1_c_q   <= '0;
      s2_min_q <= '0;
      s2_max_q <= '0;
      s3_min_q <= '0;
      s3_max_q <= '0;
      s3_off_q <= 1'b0;
    end else begin
      s1_min_q <= s1_min_d;
      s1_max_q <= s1_max_d;
      s1_c_q   <= s1_c_d;
      s2_min_q <= s2_min_d;
      s2_max_q <= s2_max_d;
      s3_min_q <= s3_min_d;
      s3_max_q <= s3_max_d;
      s3_off_q <= s3_off_d;
    end
  end

  assign pmin = s3_min_q;
  assign pmax = s3_max_q;
  assign off  = s3_off_q;

endmodule

// File: rtl/tri_bbox_clip.sv
// Triangle bounding box: three-stage pipeline producing clipped
// pixel bounds with off-screen culling and a saturating cull count.
module tri_bbox_clip
  import raster_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nd,
  output logic               us_rfd,
  input  logic [COORD_W-1:0] v1_posX,
  input  logic [COORD_W-1:0] v1_posY,
  input  logic [COORD_W-1:0] v2_posX,
  input  logic [COORD_W-1:0] v2_posY,
  input  logic [COORD_W-1:0] v3_posX,
  input  logic [COORD_W-1:0] v3_posY,
  input  logic               ds_rfd,
  output logic               rdy,
  output logic [PIX_W-1:0]   minX,
  output logic [PIX_W-1:0]   maxX,
  output logic [PIX_W-1:0]   minY,
  output logic [PIX_W-1:0]   maxY,
  output logic               culled,
  output logic [15:0]        cull_count
);

  logic adv;
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  logic [15:0] cull_count_q, cull_count_d;

  logic [PIX_W-1:0] x_min, x_max;
  logic [PIX_W-1:0] y_min, y_max;
  logic             x_off, y_off;

  assign adv    = !(v3_q && !ds_rfd);
  assign us_rfd = adv;

  bbox_axis #(
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W),
    .PIX_W   (PIX_W),
    .LIMIT   (SCREEN_W - 1)
  ) u_x (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .a    (v1_posX),
    .b    (v2_posX),
    .c    (v3_posX),
    .pmin (x_min),
    .pmax (x_max),
    .off  (x_off)
  );

  bbox_axis #(
    .COORD_W (COORD_W),
    .FRAC_W  (FRAC_W),
    .PIX_W   (PIX_W),
    .LIMIT   (SCREEN_H - 1)
  ) u_y (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .a    (v1_posY),
    .b    (v2_posY),
    .c    (v3_posY),
    .pmin (y_min),
    .pmax (y_max),
    .off  (y_off)
  );

  assign culled = x_off | y_off;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (adv) begin
      v1_d = nd;
      v2_d = v1_q;
      v3_d = v2_q;
    end
    cull_count_d = cull_count_q;
    if (v3_q && ds_rfd && culled && (cull_count_q != 16'hFFFF))
      cull_count_d = cull_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      cull_count_q <= '0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      cull_count_q <= cull_count_d;
    end
  end

  // a culled triangle reports an empty (all-zero) box
  assign rdy        = v3_q;
  assign minX       = culled ? '0 : x_min;
  assign maxX       = culled ? '0 : x_max;
  assign minY       = culled ? '0 : y_min;
  assign maxY       = culled ? '0 : y_max;
  assign cull_count = cull_count_q;

endmodule

// File: tb/tb_tri_bbox_clip.sv
// Directed bench for tri_bbox_clip: basic, clip, cull, floor,
// backpressure, mid-flight reset and cull_count saturation.
module tb_tri_bbox_clip;

  logic        clk = 1'b0;
  logic        rst;
  logic        nd;
  logic        us_rfd;
  logic [15:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic        ds_rfd;
  logic        rdy;
  logic [9:0]  minX, maxX, minY, maxY;
  logic        culled;
  logic [15:0] cull_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tri_bbox_clip dut (
    .clk        (clk),
    .rst        (rst),
    .nd         (nd),
    .us_rfd     (us_rfd),
    .v1_posX    (v1x),
    .v1_posY    (v1y),
    .v2_posX    (v2x),
    .v2_posY    (v2y),
    .v3_posX    (v3x),
    .v3_posY    (v3y),
    .ds_rfd     (ds_rfd),
    .rdy        (rdy),
    .minX       (minX),
    .maxX       (maxX),
    .minY       (minY),
    .maxY       (maxY),
    .culled     (culled),
    .cull_count (cull_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic [15:0] ax, ay, bx, by, cx, cy);
    v1x = ax; v1y = ay;
    v2x = bx; v2y = by;
    v3x = cx; v3y = cy;
  endtask

  task automatic run_tri(input string tag,
                         input logic [15:0] ax, ay, bx, by, cx, cy,
                         input int emnx, emxx, emny, emxy,
                         input logic ecul,
                         input logic [15:0] ecnt);
    ds_rfd = 1'b1;
    nd = 1'b1;
    set_v(ax, ay, bx, by, cx, cy);
    tick();
    nd = 1'b0;
    set_v(0, 0, 0, 0, 0, 0);
    tick();
    chk({tag, " rdy early"}, 32'(rdy), 0);
    tick();
    chk({tag, " rdy"}, 32'(rdy), 1);
    chk({tag, " minX"}, 32'(minX), emnx);
    chk({tag, " maxX"}, 32'(maxX), emxx);
    chk({tag, " minY"}, 32'(minY), emny);
    chk({tag, " maxY"}, 32'(maxY), emxy);
    chk({tag, " culled"}, 32'(culled), 32'(ecul));
    tick();
    chk({tag, " rdy drained"}, 32'(rdy), 0);
    chk({tag, " cull_count"}, 32'(cull_count), 32'(ecnt));
  endtask

  initial begin
    logic [3:0]  pat;
    int          sent, recv, cyc, rdy_seen;
    logic        prev_stall;
    logic [9:0]  hold_mnx, hold_mxx;

    rst = 1'b1;
    nd = 1'b0;
    ds_rfd = 1'b1;
    set_v(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset rdy", 32'(rdy), 0);
    chk("reset culled", 32'(culled), 0);
    chk("reset minX", 32'(minX), 0);
    chk("reset maxY", 32'(maxY), 0);
    chk("reset cull_count", 32'(cull_count), 0);
    chk("reset us_rfd", 32'(us_rfd), 1);

    run_tri("basic", 16'h00A0, 16'h0140, 16'h0640, 16'h0050,
            16'h0320, 16'h12C0, 10, 100, 5, 300, 1'b0, 16'd0);
    run_tri("clip", 16'hFFA8, 16'hFFF0, 16'h2BC0, 16'h00A0,
            16'h0140, 16'h1F40, 0, 639, 0, 479, 1'b0, 16'd0);
    run_tri("cullx", 16'h2800, 16'h00A0, 16'h28A0, 16'h0140,
            16'h2BC0, 16'h01E0, 0, 0, 0, 0, 1'b1, 16'd1);
    run_tri("cully", 16'h00A0, 16'hFFF0, 16'h0140, 16'hFFE0,
            16'h01E0, 16'hFFD0, 0, 0, 0, 0, 1'b1, 16'd2);
    run_tri("frac", 16'h003F, 16'h0001, 16'hFFFF, 16'h0028,
            16'h0010, 16'h0010, 0, 3, 0, 2, 1'b0, 16'd2);
    run_tri("edge_in", 16'h27FF, 16'h01DF, 16'h27F0, 16'h1DFF,
            16'h27F8, 16'h1DF0, 639, 639, 29, 479, 1'b0, 16'd2);
    run_tri("negx", 16'hFFFF, 16'h0010, 16'hFFFF, 16'h0020,
            16'hFFFF, 16'h0030, 0, 0, 0, 0, 1'b1, 16'd3);
    run_tri("point", 16'h0050, 16'h0070, 16'h0050, 16'h0070,
            16'h0050, 16'h0070, 5, 5, 7, 7, 1'b0, 16'd3);

    // backpressure: ds_rfd pattern 1,0,0,1 repeating
    pat = 4'b1001;
    sent = 0;
    recv = 0;
    cyc = 0;
    prev_stall = 1'b0;
    hold_mnx = '0;
    hold_mxx = '0;
    while (recv < 5 && cyc < 80) begin
      ds_rfd = pat[3 - (cyc % 4)];
      nd = (sent < 5);
      set_v(16'((sent * 10 + 1) * 16), 16'((sent + 50) * 16),
            16'((sent * 10 + 5) * 16), 16'((sent + 50) * 16),
            16'((sent * 10 + 3) * 16), 16'((sent + 50) * 16));
      #1;
      chk("bp us_rfd", 32'(us_rfd), 32'(!(rdy && !ds_rfd)));
      if (prev_stall) begin
        chk("bp hold rdy", 32'(rdy), 1);
        chk("bp hold minX", 32'(minX), 32'(hold_mnx));
        chk("bp hold maxX", 32'(maxX), 32'(hold_mxx));
      end
      if (rdy && ds_rfd) begin
        chk("bp minX", 32'(minX), recv * 10 + 1);
        chk("bp maxX", 32'(maxX), recv * 10 + 5);
        chk("bp minY", 32'(minY), recv + 50);
        chk("bp culled", 32'(culled), 0);
        recv++;
      end
      prev_stall = rdy && !ds_rfd;
      hold_mnx = minX;
      hold_mxx = maxX;
      if (nd && us_rfd) sent++;
      tick();
      cyc++;
    end
    chk("bp count recv", 32'(recv), 5);
    chk("bp count sent", 32'(sent), 5);
    nd = 1'b0;
    ds_rfd = 1'b1;
    tick();
    chk("bp no extra", 32'(rdy), 0);

    // reset with two triangles in flight, nd held with rst
    nd = 1'b1;
    set_v(16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0300, 16'h0300);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst rdy", 32'(rdy), 0);
    chk("rst cull_count", 32'(cull_count), 0);
    rst = 1'b0;
    nd = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy) rdy_seen++;
    end
    chk("rst no output", 32'(rdy_seen), 0);

    // saturation: 65535 culls, then one more
    ds_rfd = 1'b1;
    nd = 1'b1;
    set_v(16'h2800, 16'h00A0, 16'h28A0, 16'h0140, 16'h2BC0, 16'h01E0);
    for (int i = 0; i < 65535; i++) tick();
    nd = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("sat preload", 32'(cull_count), 32'hFFFF);
    run_tri("sat", 16'h2800, 16'h00A0, 16'h28A0, 16'h0140,
            16'h2BC0, 16'h01E0, 0, 0, 0, 0, 1'b1, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
